// File: rtl/ppe_load_tx.sv
// ppe_load_tx: serializes one PPE load job into WEIGHT, INPUT and optional START packets (START packet enabled by PPE_LOAD_TX_START_EN)
module ppe_load_tx #(
  parameter int NUM_W    = 5,
  parameter int ROW_W    = 25,
  parameter int MAX_ROWS = 25,
  parameter int MEM_AW   = 10
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  job_valid,
  output logic                  job_ready,
  input  logic [3:0]            job_dest,
  input  logic [8*NUM_W-1:0]    job_weights,
  input  logic [MEM_AW-1:0]     job_base,
  input  logic [4:0]            job_rows,
  output logic                  mem_ren,
  output logic [MEM_AW-1:0]     mem_raddr,
  input  logic [ROW_W-1:0]      mem_rdata,
  output logic                  pkt_valid,
  input  logic                  pkt_ready,
  output logic [32:0]           pkt_data,
  output logic                  job_done
);
  typedef enum logic [2:0] {
    IDLE,
    WEIGHT,
    RD,
    CAP,
    SEND,
`ifdef PPE_LOAD_TX_START_EN
    START,
`endif
    DONE
  } state_t;
  state_t               state;
  logic [3:0]           dest;
  logic [8*NUM_W-1:0]   weights;
  logic [MEM_AW-1:0]    base;
  logic [4:0]           rows;
  logic [4:0]           row;
  logic [2:0]           widx;
  logic                 hs;
  logic                 last_w;
  logic [4:0]           row_nx;
  logic [4:0]           rows_clamped;
  function automatic logic [32:0] wpkt(input logic [3:0] d, input logic [8*NUM_W-1:0] w, input logic [2:0] i);
    return {d, 4'h1, 14'd0, i, w[8*i +: 8]};
  endfunction
  assign hs           = pkt_valid & pkt_ready;
  assign last_w       = widx == 3'(NUM_W - 1);
  assign row_nx       = row + 5'd1;
  assign rows_clamped = job_rows > 5'(MAX_ROWS) ? 5'(MAX_ROWS) : job_rows;
  // job sequencer: every output is registered; the packet register holds captured row data across backpressure
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      job_ready <= 1'b0;
      pkt_valid <= 1'b0;
      pkt_data  <= '0;
      mem_ren   <= 1'b0;
      mem_raddr <= '0;
      job_done  <= 1'b0;
      row       <= '0;
      widx      <= '0;
      dest      <= '0;
      weights   <= '0;
      base      <= '0;
      rows      <= '0;
    end else begin
      mem_ren  <= 1'b0;
      job_done <= 1'b0;
      case (state)
        IDLE: begin
          job_ready <= ~(job_valid & job_ready);
          if (job_valid && job_ready) begin
            dest      <= job_dest;
            weights   <= job_weights;
            base      <= job_base;
            rows      <= rows_clamped;
            row       <= '0;
            widx      <= '0;
            pkt_data  <= wpkt(job_dest, job_weights, 3'd0);
            pkt_valid <= 1'b1;
            state     <= WEIGHT;
          end
        end
        WEIGHT: if (hs) begin
          if (!last_w) begin
            widx     <= widx + 3'd1;
            pkt_data <= wpkt(dest, weights, widx + 3'd1);
          end else if (rows != '0) begin
            pkt_valid <= 1'b0;
            mem_ren   <= 1'b1;
            mem_raddr <= base;
            state     <= RD;
          end else begin
`ifdef PPE_LOAD_TX_START_EN
            pkt_data <= {dest, 4'h4, 25'd0};
            state    <= START;
`else
            pkt_valid <= 1'b0;
            job_done  <= 1'b1;
            state     <= DONE;
`endif
          end
        end
        RD: state <= CAP;
        CAP: begin
          pkt_data  <= {dest, row == '0 ? 4'h3 : 4'h2, 25'(mem_rdata)};
          pkt_valid <= 1'b1;
          state     <= SEND;
        end
        SEND: if (hs) begin
          row <= row_nx;
          if (row_nx < rows) begin
            pkt_valid <= 1'b0;
            mem_ren   <= 1'b1;
            mem_raddr <= base + MEM_AW'(row_nx);
            state     <= RD;
          end else begin
`ifdef PPE_LOAD_TX_START_EN
            pkt_data <= {dest, 4'h4, 25'd0};
            state    <= START;
`else
            pkt_valid <= 1'b0;
            job_done  <= 1'b1;
            state     <= DONE;
`endif
          end
        end
`ifdef PPE_LOAD_TX_START_EN
        START: if (hs) begin
          pkt_valid <= 1'b0;
          job_done  <= 1'b1;
          state     <= DONE;
        end
`endif
        DONE: begin
          job_ready <= 1'b1;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_ppe_load_tx.sv
// tb_ppe_load_tx: randomized self-checking bench comparing the packet stream against a job-level reference list
module tb_ppe_load_tx;
  localparam int NUM_W    = 5;
  localparam int MAX_ROWS = 25;
`ifdef PPE_LOAD_TX_START_EN
  localparam int HAS_START = 1;
`else
  localparam int HAS_START = 0;
`endif
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        job_valid = 1'b0;
  logic        job_ready;
  logic [3:0]  job_dest = '0;
  logic [39:0] job_weights = '0;
  logic [9:0]  job_base = '0;
  logic [4:0]  job_rows = '0;
  logic        mem_ren;
  logic [9:0]  mem_raddr;
  logic [24:0] mem_rdata = '0;
  logic        pkt_valid;
  logic        pkt_ready = 1'b0;
  logic [32:0] pkt_data;
  logic        job_done;
  logic [24:0] mem [0:1023];
  int errors = 0;
  int checks = 0;
  logic [32:0] got_pkt[$];
  logic [32:0] exp_pkt[$];
  int          got_cyc[$];
  logic [9:0]  got_addr[$];
  int done_cyc, done_cnt, stab_err, ren_pend, first_v;
  bit timeout, ready_after, done_after;

  always #5 clk = ~clk;

  ppe_load_tx dut (
    .clk(clk), .reset(reset), .job_valid(job_valid), .job_ready(job_ready),
    .job_dest(job_dest), .job_weights(job_weights), .job_base(job_base), .job_rows(job_rows),
    .mem_ren(mem_ren), .mem_raddr(mem_raddr), .mem_rdata(mem_rdata),
    .pkt_valid(pkt_valid), .pkt_ready(pkt_ready), .pkt_data(pkt_data), .job_done(job_done)
  );

  // one-cycle-latency memory; returns junk when not read so mis-timed captures show up
  always @(posedge clk) mem_rdata <= mem_ren ? mem[mem_raddr] : 25'($urandom);

  // reference: the packet list a job must produce
  task automatic build_exp(input logic [3:0] d, input logic [39:0] w, input logic [9:0] b, input logic [4:0] r);
    int n;
    n = (int'(r) > MAX_ROWS) ? MAX_ROWS : int'(r);
    exp_pkt.delete();
    for (int i = 0; i < NUM_W; i++) exp_pkt.push_back({d, 4'h1, 14'h0, 3'(i), w[8*i +: 8]});
    for (int j = 0; j < n; j++) exp_pkt.push_back({d, (j == 0) ? 4'h3 : 4'h2, mem[(int'(b) + j) % 1024]});
    if (HAS_START != 0) exp_pkt.push_back({d, 4'h4, 25'h0});
  endtask

  // offers one job and records everything the DUT does until job_done
  task automatic drive_job(input logic [3:0] d, input logic [39:0] w, input logic [9:0] b, input logic [4:0] r, input bit bp);
    logic prev_pend;
    logic [32:0] prev_data;
    got_pkt.delete(); got_cyc.delete(); got_addr.delete();
    done_cyc = -1; done_cnt = 0; stab_err = 0; ren_pend = 0; first_v = -1;
    prev_pend = 1'b0; prev_data = '0;
    for (int c = 0; c < 20 && !job_ready; c++) @(negedge clk);
    job_dest = d; job_weights = w; job_base = b; job_rows = r; job_valid = 1'b1;
    pkt_ready = bp ? 1'($urandom_range(0, 1)) : 1'b1;
    for (int c = 1; c <= 3000 && done_cnt == 0; c++) begin
      @(negedge clk);
      if (c == 1) begin
        job_valid = 1'b0;
        job_dest = 4'($urandom); job_weights = 40'({$urandom, $urandom});
        job_base = 10'($urandom); job_rows = 5'($urandom);
      end
      if (prev_pend && (!pkt_valid || pkt_data !== prev_data)) stab_err++;
      if (pkt_valid && first_v < 0) first_v = c;
      if (mem_ren) begin
        got_addr.push_back(mem_raddr);
        if (pkt_valid) ren_pend++;
      end
      if (job_done) begin done_cnt++; done_cyc = c; end
      pkt_ready = bp ? 1'($urandom_range(0, 1)) : 1'b1;
      if (pkt_valid && pkt_ready) begin got_pkt.push_back(pkt_data); got_cyc.push_back(c); end
      prev_pend = pkt_valid && !pkt_ready;
      prev_data = pkt_data;
    end
    timeout = (done_cnt == 0);
    @(negedge clk);
    ready_after = job_ready;
    done_after = job_done;
  endtask

  task automatic test_reset;
    reset = 1'b1;
    repeat (3) @(negedge clk);
    checks++; if (job_ready !== 1'b0) begin errors++; $display("FAIL rst_job_ready got=%b exp=0", job_ready); end
    checks++; if (pkt_valid !== 1'b0) begin errors++; $display("FAIL rst_pkt_valid got=%b exp=0", pkt_valid); end
    checks++; if (pkt_data !== 33'h0) begin errors++; $display("FAIL rst_pkt_data got=%h exp=0", pkt_data); end
    checks++; if (mem_ren !== 1'b0) begin errors++; $display("FAIL rst_mem_ren got=%b exp=0", mem_ren); end
    checks++; if (mem_raddr !== 10'h0) begin errors++; $display("FAIL rst_mem_raddr got=%h exp=0", mem_raddr); end
    checks++; if (job_done !== 1'b0) begin errors++; $display("FAIL rst_job_done got=%b exp=0", job_done); end
    reset = 1'b0;
    @(negedge clk);
    checks++; if (job_ready !== 1'b1) begin errors++; $display("FAIL rst_release_ready got=%b exp=1", job_ready); end
  endtask

  task automatic test_weights_only;
    build_exp(4'h6, 40'h0504030201, 10'h0, 5'd0);
    drive_job(4'h6, 40'h0504030201, 10'h0, 5'd0, 1'b0);
    checks++; if (timeout) begin errors++; $display("FAIL w_timeout got=no_done exp=done"); end
    checks++; if (got_pkt.size() != exp_pkt.size()) begin errors++; $display("FAIL w_count got=%0d exp=%0d", got_pkt.size(), exp_pkt.size()); end
    foreach (exp_pkt[i]) begin
      checks++;
      if (i >= got_pkt.size() || got_pkt[i] !== exp_pkt[i]) begin
        errors++; $display("FAIL w_pkt[%0d] got=%h exp=%h", i, (i < got_pkt.size()) ? got_pkt[i] : 33'bx, exp_pkt[i]);
      end
    end
    checks++; if (got_pkt.size() < 5 || got_pkt[0] !== 33'h0C2000001 || got_pkt[4] !== 33'h0C2000405) begin
      errors++; $display("FAIL w_const got=%h,%h exp=0c2000001,0c2000405", (got_pkt.size() > 0) ? got_pkt[0] : 33'bx, (got_pkt.size() > 4) ? got_pkt[4] : 33'bx);
    end
    checks++; if (first_v != 1) begin errors++; $display("FAIL w_first_latency got=%0d exp=1", first_v); end
    for (int i = 0; i < NUM_W && i < got_cyc.size(); i++) begin
      checks++; if (got_cyc[i] != i + 1) begin errors++; $display("FAIL w_cycle[%0d] got=%0d exp=%0d", i, got_cyc[i], i + 1); end
    end
    checks++; if (got_addr.size() != 0) begin errors++; $display("FAIL w_mem_ren got=%0d exp=0", got_addr.size()); end
    checks++; if (done_cyc != 6 + HAS_START) begin errors++; $display("FAIL w_done_cycle got=%0d exp=%0d", done_cyc, 6 + HAS_START); end
    checks++; if (ready_after !== 1'b1 || done_after !== 1'b0) begin errors++; $display("FAIL w_after got=ready%b,done%b exp=ready1,done0", ready_after, done_after); end
  endtask

  task automatic test_three_rows;
    logic [3:0] d;
    logic [39:0] w;
    d = 4'($urandom); w = 40'({$urandom, $urandom});
    mem[10'h3FE] = 25'h1ABCDEF; mem[10'h3FF] = 25'h0000001; mem[10'h000] = 25'h1FFFFFF;
    build_exp(d, w, 10'h3FE, 5'd3);
    drive_job(d, w, 10'h3FE, 5'd3, 1'b0);
    checks++; if (timeout) begin errors++; $display("FAIL r3_timeout got=no_done exp=done"); end
    checks++; if (got_addr.size() != 3 || got_addr[0] !== 10'h3FE || got_addr[1] !== 10'h3FF || got_addr[2] !== 10'h000) begin
      errors++; $display("FAIL r3_addr got_n=%0d first=%h exp=3fe,3ff,000", got_addr.size(), (got_addr.size() > 0) ? got_addr[0] : 10'bx);
    end
    checks++; if (got_pkt.size() != exp_pkt.size()) begin errors++; $display("FAIL r3_count got=%0d exp=%0d", got_pkt.size(), exp_pkt.size()); end
    foreach (exp_pkt[i]) begin
      checks++;
      if (i >= got_pkt.size() || got_pkt[i] !== exp_pkt[i]) begin
        errors++; $display("FAIL r3_pkt[%0d] got=%h exp=%h", i, (i < got_pkt.size()) ? got_pkt[i] : 33'bx, exp_pkt[i]);
      end
    end
    for (int j = 0; j < 3 && NUM_W + j < got_cyc.size(); j++) begin
      checks++; if (got_cyc[NUM_W + j] != 8 + 3 * j) begin errors++; $display("FAIL r3_row_cycle[%0d] got=%0d exp=%0d", j, got_cyc[NUM_W + j], 8 + 3 * j); end
    end
    checks++; if (got_cyc.size() == 0 || done_cyc != got_cyc[got_cyc.size() - 1] + 1) begin errors++; $display("FAIL r3_done_cycle got=%0d exp=last_hs+1", done_cyc); end
  endtask

  task automatic test_backpressure;
    logic [3:0] d;
    logic [39:0] w;
    logic [9:0] b;
    logic [4:0] r;
    logic [32:0] ref_pkt[$];
    for (int it = 0; it < 3; it++) begin
      d = 4'($urandom); w = 40'({$urandom, $urandom}); b = 10'($urandom); r = 5'($urandom_range(1, 6));
      build_exp(d, w, b, r);
      drive_job(d, w, b, r, 1'b0);
      ref_pkt = got_pkt;
      drive_job(d, w, b, r, 1'b1);
      checks++; if (timeout) begin errors++; $display("FAIL bp_timeout[%0d] got=no_done exp=done", it); end
      checks++; if (stab_err != 0) begin errors++; $display("FAIL bp_stable[%0d] got=%0d exp=0", it, stab_err); end
      checks++; if (ren_pend != 0) begin errors++; $display("FAIL bp_ren_pending[%0d] got=%0d exp=0", it, ren_pend); end
      checks++; if (got_addr.size() != int'(r)) begin errors++; $display("FAIL bp_reads[%0d] got=%0d exp=%0d", it, got_addr.size(), r); end
      checks++; if (got_pkt != ref_pkt) begin errors++; $display("FAIL bp_vs_noblock[%0d] got_n=%0d exp_n=%0d", it, got_pkt.size(), ref_pkt.size()); end
      foreach (exp_pkt[i]) begin
        checks++;
        if (i >= got_pkt.size() || got_pkt[i] !== exp_pkt[i]) begin
          errors++; $display("FAIL bp_pkt[%0d][%0d] got=%h exp=%h", it, i, (i < got_pkt.size()) ? got_pkt[i] : 33'bx, exp_pkt[i]);
        end
      end
      checks++; if (got_cyc.size() == 0 || done_cyc != got_cyc[got_cyc.size() - 1] + 1) begin errors++; $display("FAIL bp_done_cycle[%0d] got=%0d exp=last_hs+1", it, done_cyc); end
    end
  endtask

  task automatic test_clamp;
    logic [3:0] d;
    logic [39:0] w;
    logic [9:0] b;
    int n_in;
    d = 4'($urandom); w = 40'({$urandom, $urandom}); b = 10'($urandom);
    build_exp(d, w, b, 5'd31);
    drive_job(d, w, b, 5'd31, 1'b0);
    n_in = 0;
    foreach (got_pkt[i]) if (got_pkt[i][28:25] == 4'h2 || got_pkt[i][28:25] == 4'h3) n_in++;
    checks++; if (n_in != MAX_ROWS) begin errors++; $display("FAIL clamp_inputs got=%0d exp=%0d", n_in, MAX_ROWS); end
    checks++; if (got_addr.size() != MAX_ROWS) begin errors++; $display("FAIL clamp_reads got=%0d exp=%0d", got_addr.size(), MAX_ROWS); end
    checks++; if (got_pkt != exp_pkt) begin errors++; $display("FAIL clamp_stream got_n=%0d exp_n=%0d", got_pkt.size(), exp_pkt.size()); end
  endtask

  task automatic test_reset_midjob;
    int n_hs;
    bit hit, saw_done;
    logic [3:0] d;
    logic [39:0] w;
    logic [9:0] b;
    n_hs = 0; hit = 1'b0; saw_done = 1'b0;
    job_dest = 4'h9; job_weights = 40'({$urandom, $urandom}); job_base = 10'($urandom); job_rows = 5'd3;
    job_valid = 1'b1; pkt_ready = 1'b1;
    for (int c = 1; c <= 200 && !hit; c++) begin
      @(negedge clk);
      if (c == 1) job_valid = 1'b0;
      if (job_done) saw_done = 1'b1;
      if (n_hs == NUM_W + 1) pkt_ready = 1'b0;
      if (!pkt_ready && pkt_valid) hit = 1'b1;
      else if (pkt_valid && pkt_ready) n_hs++;
    end
    checks++; if (!hit || pkt_data[28:25] !== 4'h2) begin errors++; $display("FAIL rm_second_input got=hit%b,op%h exp=hit1,op2", hit, pkt_data[28:25]); end
    reset = 1'b1;
    @(negedge clk);
    checks++; if (pkt_valid !== 1'b0 || job_done !== 1'b0 || mem_ren !== 1'b0 || job_ready !== 1'b0) begin
      errors++; $display("FAIL rm_reset_out got=v%b,d%b,r%b,rdy%b exp=0,0,0,0", pkt_valid, job_done, mem_ren, job_ready);
    end
    reset = 1'b0;
    @(negedge clk);
    checks++; if (job_ready !== 1'b1 || saw_done || job_done !== 1'b0) begin errors++; $display("FAIL rm_recover got=rdy%b,done_seen%b exp=rdy1,done_seen0", job_ready, saw_done); end
    d = 4'($urandom); w = 40'({$urandom, $urandom}); b = 10'($urandom);
    build_exp(d, w, b, 5'd2);
    drive_job(d, w, b, 5'd2, 1'b1);
    checks++; if (timeout || got_pkt != exp_pkt) begin errors++; $display("FAIL rm_new_job got_n=%0d exp_n=%0d timeout=%b", got_pkt.size(), exp_pkt.size(), timeout); end
  endtask

  task automatic test_back_to_back;
    logic [3:0] d;
    logic [39:0] w;
    logic [9:0] b;
    logic [4:0] r;
    for (int it = 0; it < 4; it++) begin
      d = 4'($urandom); w = 40'({$urandom, $urandom}); b = 10'($urandom); r = 5'($urandom_range(0, 8));
      build_exp(d, w, b, r);
      drive_job(d, w, b, r, it[0]);
      checks++; if (timeout || got_pkt != exp_pkt) begin errors++; $display("FAIL b2b_stream[%0d] got_n=%0d exp_n=%0d timeout=%b", it, got_pkt.size(), exp_pkt.size(), timeout); end
      checks++; if (done_cnt != 1 || ready_after !== 1'b1) begin errors++; $display("FAIL b2b_done[%0d] got=cnt%0d,rdy%b exp=cnt1,rdy1", it, done_cnt, ready_after); end
    end
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) mem[i] = 25'($urandom);
    test_reset;
    test_weights_only;
    test_three_rows;
    test_backpressure;
    test_clamp;
    test_reset_midjob;
    test_back_to_back;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/ppe_load_tx.md
# ppe_load_tx

Clocked packet transmitter that feeds a PPE. It accepts one load job at a time: a destination PE, a weight row, and an input-row range. It emits the job as 33-bit packets on a valid/ready stream that enters the PPE's depacketizer through the NoC adapter. The packets are weight writes, then input-row writes fetched from the input spike memory, then an optional START. Packet layout: [32:29] dest, [28:25] opcode, [24:0] data.

## Interface
- NUM_W, 5, weights per job; each weight is 8 bits, and NUM_W must be ≤ 8 (3-bit weight index).
- ROW_W, 25, input row width in bits; must be ≤ 25.
- MAX_ROWS, 25, maximum input rows per job.
- MEM_AW, 10, input memory address width.
- clk  in  1  clock, rising edge.
- reset  in  1  synchronous, active-high.
- job_valid  in  1  job offered.
- job_ready  out  1  block idle and can accept a job.
- job_dest  in  4  destination PE address.
- job_weights  in  8*NUM_W  weight i is at [8i+7:8i].
- job_base  in  MEM_AW  first input row address.
- job_rows  in  5  number of input rows.
- mem_ren  out  1  input memory read enable.
- mem_raddr  out  MEM_AW  input memory read address.
- mem_rdata  in  ROW_W  row data; valid exactly 1 cycle after mem_ren.
- pkt_valid  out  1  packet valid.
- pkt_ready  in  1  downstream accepts.
- pkt_data  out  33  packet.
- job_done  out  1  one-cycle pulse after the job's last packet handshake.

## Operation
- Opcodes:
  - 4'h1 WEIGHT: data[10:8] = index, data[7:0] = weight, data[24:11] = 0.
  - 4'h3 INPUT_FIRST: data = row, zero-extended.
  - 4'h2 INPUT_NEXT: data = row, zero-extended. The PPE resets its input write pointer on INPUT_FIRST and increments it on each INPUT packet.
  - 4'h4 START: data = 0.
- Every packet's dest field equals the latched job_dest.
- FSM states:
  - IDLE: job_ready = 1. A handshake latches all job fields and goes to WEIGHT.
  - WEIGHT: sends indices 0..NUM_W-1 in order. After the last handshake, goes to RD if rows > 0, else to START (or DONE).
  - RD: mem_ren = 1 for one cycle with mem_raddr = base + row, modulo 2^MEM_AW. Goes to CAP.
  - CAP: registers mem_rdata into the packet register with pkt_valid = 1, then goes to SEND.
  - SEND: holds until handshake. Then row++; if row < rows, goes to RD, else to START (or DONE).
  - START: sends one START packet, then goes to DONE.
  - DONE: job_done = 1 for one cycle, then goes to IDLE.
- job_rows > MAX_ROWS is clamped to MAX_ROWS at latch time.
- job_rows = 0: no input packets and no memory reads.
- Stream rules:
  - pkt_data and pkt_valid are registered.
  - Once pkt_valid is asserted, it and pkt_data stay stable until a cycle with pkt_ready = 1.
  - pkt_ready may be high before pkt_valid; no handshake occurs while pkt_valid = 0.
- Job inputs are sampled only at the job handshake; later changes have no effect.

## Timing
- Reset values: job_ready = 0 during reset and 1 the cycle after; pkt_valid = 0, pkt_data = 0, mem_ren = 0, mem_raddr = 0, job_done = 0; FSM in IDLE; row and weight counters 0.
- Job handshake at cycle T puts the first WEIGHT packet valid at T+1.
- WEIGHT packets sustain one per cycle while pkt_ready = 1.
- Input rows take at least 3 cycles each: RD, CAP, SEND with immediate ready. mem_ren is never asserted while a packet is pending.
- job_done is asserted in the cycle after the final handshake. job_ready returns the cycle after that.
- Reset asserted mid-job drops the job. All outputs take their reset values at the next edge, and no partial job_done is produced.
- Backpressure never causes a memory re-read. Captured data is held in the packet register.

## Configuration
- PPE_LOAD_TX_START_EN:
  - Defined: START state is present and a START packet ends every job, including jobs with rows = 0.
  - Undefined: the START state is compiled out; the last INPUT (or last WEIGHT) handshake goes directly to DONE, and opcode 4'h4 is never emitted.

## Test plan
- Weights only: job dest = 4'h6, weights = {8'h05, 8'h04, 8'h03, 8'h02, 8'h01}, rows = 0, pkt_ready held 1.
  - Packets on consecutive cycles: 33'h0C2000001 through 33'h0C2000405, then START 33'h0C8000000 with the macro defined.
  - job_done follows; no mem_ren.
- Three rows: base = 10'h3FE, memory holds 25'h1ABCDEF, 25'h0000001, 25'h1FFFFFF.
  - mem_raddr sequence is 3FE, 3FF, 000 (wrap).
  - Opcodes are 3, 2, 2 with the row data unchanged.
- Backpressure: pkt_ready toggles 0/1 randomly.
  - pkt_data is stable while pkt_valid = 1 and pkt_ready = 0.
  - Packet order and count are identical to the no-backpressure run; one mem_ren per row.
- Clamp: rows = 31 sends exactly 25 INPUT packets.
- Reset at the 2nd INPUT packet while pkt_ready = 0: next cycle pkt_valid = 0 and job_done = 0; job_ready = 1 the following cycle; a new job then completes correctly.
- Macro undefined: with the first test's job, the fifth WEIGHT handshake is followed directly by job_done and no START packet.
